// File: rtl/day_to_date_if.sv
// Handshake and result bundle for the day_to_date converter.
// The master side issues requests and the slave side returns calendar results.
interface day_to_date_if;
   logic        start;
   logic [15:0] day_count;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  year;
   logic [7:0]  month;
   logic [7:0]  day;
   logic [2:0]  day_of_week;

   modport master (
      output start, day_count,
      input  busy, done, err, year, month, day, day_of_week
   );

   modport slave (
      input  start, day_count,
      output busy, done, err, year, month, day, day_of_week
   );
endinterface

// File: rtl/day_to_date.sv
// Serial subtractive day-count to calendar-date converter.
// Covers 2000-01-01 to 2099-12-31 and strips whole years, then whole months.
module day_to_date (
   input logic         clk,
   input logic         rst_n,
   day_to_date_if.slave bus
);

   typedef enum logic [1:0] {IDLE, YEAR, MONTH, FIN} state_t;

   localparam logic [15:0] MAX_DAY = 16'd36524;

   state_t      state, state_nx;
   logic [15:0] rem;
   logic [6:0]  yr;
   logic [3:0]  mon;
   logic [2:0]  dow;

   logic        leap;
   logic [15:0] ylen;
   logic [2:0]  ystep;
   logic [4:0]  mlen;
   logic [2:0]  mstep;
   logic        ld, ysub, msub, fin, bad;
   logic [5:0]  fsum;

   // Advance a weekday index by a step below 7, staying within 0..6.
   function automatic logic [2:0] add7(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 4'd7) s = s - 4'd7;
      return s[2:0];
   endfunction

   assign leap  = (yr[1:0] == 2'd0);
   assign ylen  = leap ? 16'd366 : 16'd365;
   assign ystep = leap ? 3'd2 : 3'd1;
   assign fsum  = {1'b0, rem[4:0]} + {3'b000, dow};
   assign bus.busy = (state != IDLE);

   // Month length and its weekday shift for the month being stripped.
   always_comb begin
      mlen  = 5'd31;
      mstep = 3'd3;
      unique case (mon)
         4'd2: begin
            mlen  = leap ? 5'd29 : 5'd28;
            mstep = leap ? 3'd1 : 3'd0;
         end
         4'd4, 4'd6, 4'd9, 4'd11: begin
            mlen  = 5'd30;
            mstep = 3'd2;
         end
         default: begin
            mlen  = 5'd31;
            mstep = 3'd3;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and datapath control strobes.
   always_comb begin
      state_nx = state;
      ld       = 1'b0;
      ysub     = 1'b0;
      msub     = 1'b0;
      fin      = 1'b0;
      bad      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.day_count > MAX_DAY) begin
                  bad = 1'b1;
               end else begin
                  ld       = 1'b1;
                  state_nx = YEAR;
               end
            end
         end
         YEAR: begin
            if (rem >= ylen) ysub     = 1'b1;
            else             state_nx = MONTH;
         end
         MONTH: begin
            if (rem >= {11'd0, mlen}) msub     = 1'b1;
            else                      state_nx = FIN;
         end
         FIN: begin
            fin      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Working registers, error flag and the registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem             <= 16'd0;
         yr              <= 7'd0;
         mon             <= 4'd1;
         dow             <= 3'd0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
         bus.year        <= 8'd0;
         bus.month       <= 8'd1;
         bus.day         <= 8'd1;
         bus.day_of_week <= 3'd0;
      end else begin
         bus.done <= fin | bad;
         if (ld) begin
            rem     <= bus.day_count;
            yr      <= 7'd0;
            mon     <= 4'd1;
            dow     <= 3'd0;
            bus.err <= 1'b0;
         end
         if (bad) bus.err <= 1'b1;
         if (ysub) begin
            rem <= rem - ylen;
            yr  <= yr + 7'd1;
            dow <= add7(dow, ystep);
         end
         if (msub) begin
            rem <= rem - {11'd0, mlen};
            mon <= mon + 4'd1;
            dow <= add7(dow, mstep);
         end
         if (fin) begin
            bus.year        <= {1'b0, yr};
            bus.month       <= {4'd0, mon};
            bus.day         <= 8'(rem) + 8'd1;
            bus.day_of_week <= 3'(fsum % 6'd7);
         end
      end
   end

endmodule

// File: tb/tb_day_to_date.sv
// Directed table-driven bench for day_to_date.
// Latency below counts edges after the accepting edge until done is seen.
module tb_day_to_date;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   day_to_date_if bus ();

   day_to_date dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int dc;
      int err;
      int yr;
      int mo;
      int dy;
      int dw;
      int lat;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Present a request for one accepting edge; reports busy just after it.
   task automatic kick(input int dc, output int bz);
      bus.day_count = dc[15:0];
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bz            = int'(bus.busy);
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!bus.done && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic check_out(input string tag, input vec_t v, input int cnt);
      chk({tag, " latency"}, cnt, v.lat);
      chk({tag, " err"}, int'(bus.err), v.err);
      chk({tag, " year"}, int'(bus.year), v.yr);
      chk({tag, " month"}, int'(bus.month), v.mo);
      chk({tag, " day"}, int'(bus.day), v.dy);
      chk({tag, " dow"}, int'(bus.day_of_week), v.dw);
      chk({tag, " busy at done"}, int'(bus.busy), 0);
   endtask

   initial begin
      int   cnt;
      int   bz;
      int   seen;
      vec_t v;

      tests = 0;
      fails = 0;

      tbl[0] = '{0,     0, 0,  1,  1,  0, 3};
      tbl[1] = '{59,    0, 0,  2,  29, 3, 4};
      tbl[2] = '{60,    0, 0,  3,  1,  4, 5};
      tbl[3] = '{366,   0, 1,  1,  1,  2, 4};
      tbl[4] = '{36524, 0, 99, 12, 31, 5, 113};
      tbl[5] = '{36525, 1, 99, 12, 31, 5, 0};
      tbl[6] = '{31,    0, 0,  2,  1,  3, 4};
      tbl[7] = '{365,   0, 0,  12, 31, 1, 14};
      tbl[8] = '{1461,  0, 4,  1,  1,  5, 7};
      tbl[9] = '{425,   0, 1,  3,  1,  5, 6};

      bus.start     = 1'b0;
      bus.day_count = 16'd0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", int'(bus.busy), 0);
      chk("rst done", int'(bus.done), 0);
      chk("rst err", int'(bus.err), 0);
      chk("rst year", int'(bus.year), 0);
      chk("rst month", int'(bus.month), 1);
      chk("rst day", int'(bus.day), 1);
      chk("rst dow", int'(bus.day_of_week), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         kick(tbl[i].dc, bz);
         chk($sformatf("v%0d busy after accept", i), bz, tbl[i].err ? 0 : 1);
         wait_done(cnt);
         check_out($sformatf("v%0d", i), tbl[i], cnt);
         @(posedge clk); #1;
         chk($sformatf("v%0d done pulse", i), int'(bus.done), 0);
      end

      // Restart and day_count changes while busy must not disturb the result.
      kick(60, bz);
      @(posedge clk); #1;
      bus.day_count = 16'd36524;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.day_count = 16'd1000;
      wait_done(cnt);
      check_out("ignore", tbl[2], cnt + 2);
      @(posedge clk); #1;

      // Back-to-back: second request raised during the done cycle.
      kick(59, bz);
      wait_done(cnt);
      check_out("b2b first", tbl[1], cnt);
      kick(366, bz);
      chk("b2b busy", bz, 1);
      wait_done(cnt);
      check_out("b2b second", tbl[3], cnt);
      @(posedge clk); #1;

      // Reset in the middle of a long conversion.
      kick(36524, bz);
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid rst busy", int'(bus.busy), 0);
      chk("mid rst done", int'(bus.done), 0);
      chk("mid rst year", int'(bus.year), 0);
      chk("mid rst month", int'(bus.month), 1);
      chk("mid rst day", int'(bus.day), 1);
      chk("mid rst dow", int'(bus.day_of_week), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 130; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      chk("no done after abort", seen, 0);
      v = tbl[9];
      kick(v.dc, bz);
      wait_done(cnt);
      check_out("after rst", v, cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/day_to_date.md
DAY_TO_DATE -- requirements
Module: day_to_date

Interface
REQ-001 SHALL have parameters: none (fixed epoch 2000-01-01, range 2000-01-01..2099-12-31).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 day_count  input  16  days elapsed since 2000-01-01 (0 = 2000-01-01).
REQ-006 busy  output  1  high while a conversion is in progress (not IDLE).
REQ-007 done  output  1  one-cycle pulse when outputs have been updated or an error has been flagged.
REQ-008 err  output  1  set with done when day_count > 36524; cleared on next accepted start.
REQ-009 year  output  8  year offset from 2000 (0..99).
REQ-010 month  output  8  month 1..12.
REQ-011 day  output  8  day of month 1..31.
REQ-012 day_of_week  output  3  0=Sat,1=Sun,2=Mon,3=Tue,4=Wed,5=Thu,6=Fri (same encoding as the Zeller block).

Function
REQ-013 SHALL be a serial subtractive converter with states IDLE, YEAR, MONTH, FIN.
REQ-014 IDLE, start=1, day_count<=36524: latch rem=day_count, yr=0, mon=1, dow=0; clear err; go to YEAR.
REQ-015 IDLE, start=1, day_count>36524: next edge pulse done=1, set err=1; year/month/day/day_of_week unchanged; stay in IDLE.
REQ-016 Leap year iff (yr mod 4)==0 (valid for 2000..2099); ylen=366 if leap, else 365.
REQ-017 YEAR, per cycle: if rem>=ylen then rem-=ylen, yr+=1, dow=(dow+ylen mod 7) mod 7; else go to MONTH.
REQ-018 Month lengths: 31,28/29,31,30,31,30,31,31,30,31,30,31; Feb=29 iff yr leap.
REQ-019 MONTH, per cycle: if rem>=mlen then rem-=mlen, mon+=1, dow=(dow+mlen mod 7) mod 7; else go to FIN.
REQ-020 FIN: register year=yr, month=mon, day=rem+1, day_of_week=(dow+rem) mod 7; pulse done=1; go to IDLE.
REQ-021 Latency: start sampled at edge 0, done high after edge Y+M+3 (Y = whole years, M = whole months subtracted).
REQ-022 busy SHALL be high from the edge after start acceptance until the edge on which done asserts; low in IDLE.
REQ-023 start while busy SHALL be ignored; day_count changes after acceptance SHALL not affect the result.
REQ-024 start in the same cycle done is high SHALL be accepted (back-to-back).
REQ-025 Outputs SHALL change only on done (FIN) or reset; they hold the last valid result otherwise.
REQ-026 Internal rem 16 bits, never negative; the mod-7 accumulators never exceed 6 after update.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, err=0, year=0, month=1, day=1, day_of_week=0.
REQ-028 Reset mid-conversion SHALL abort it; no done is produced for the aborted request.

Verification
REQ-029 day_count=0 -> done after 3 cycles; year=0, month=1, day=1, dow=0, err=0.
REQ-030 day_count=59 -> 2000-02-29, dow=3, latency 4; day_count=60 -> 2000-03-01, dow=4, latency 5.
REQ-031 day_count=366 -> year=1, month=1, day=1, dow=2; day_count=36524 -> year=99, month=12, day=31, dow=5, latency 113.
REQ-032 day_count=36525 -> done after 1 cycle with err=1, outputs unchanged; next valid start clears err.
REQ-033 start pulsed while busy -> ignored, first result correct; back-to-back start on done cycle -> both results correct.
REQ-034 rst_n low mid-conversion of 36524 -> outputs at reset values, no done; new start then converts correctly.
